camino_datos_mult: RTL

Shift-add multiplier datapath that executes the per-cycle commands issued by the multiplier control unit: CargaQ, DesplazaQ, ResetA, CargaA and Fin.
- Holds the multiplicand M, accumulator A with carry C, multiplier Q, and a shift counter.
- Returns q0 to the control unit and publishes the 2*WIDTH product with a one-cycle valid strobe.
- Sits between the control unit and the top level of the practice design.

---
 rtl/mult_pkg.sv | 29 ++
 rtl/camino_datos_mult_contador.sv | 39 +++
 rtl/camino_datos_mult.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// ============================================================================
// mult_pkg
// Shared constants for the shift-add multiplier datapath: the default operand
// width, the shift-counter width helper, and the bit positions used when the
// five control strobes are bundled into one command vector.
// Revision: 1.0
// ============================================================================
`default_nettype none

package mult_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // Bit positions of the control strobes inside a bundled 5-bit command.
    localparam int CMD_CARGAQ    = 0;
    localparam int CMD_DESPLAZAQ = 1;
    localparam int CMD_RESETA    = 2;
    localparam int CMD_CARGAA    = 3;
    localparam int CMD_FIN       = 4;
    localparam int CMD_BITS      = 5;

    // The counter must be able to hold the value WIDTH itself.
    function automatic int calc_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/camino_datos_mult_contador.sv
// ============================================================================
// contador_desplazamientos
// Saturating shift counter. Cleared synchronously when a new operation is
// loaded and incremented on every shift; stops at WIDTH and flags lleno.
// Revision: 1.0
// ============================================================================
`default_nettype none

module contador_desplazamientos #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    output logic lleno
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(WIDTH);

    logic [CNT_W-1:0] cnt;

    assign lleno = (cnt == FULL);

    // Count shifts, saturating at WIDTH; clear has priority over increment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (inc && !lleno) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/camino_datos_mult.sv
// ============================================================================
// camino_datos_mult
// Shift-add multiplier datapath driven by the control unit strobes CargaQ,
// DesplazaQ, ResetA, CargaA and Fin. Holds M, {C,A}, Q and a shift counter,
// returns q0 and publishes the 2*WIDTH product with a one-cycle valid pulse.
// Optional protocol checker: define CAMINO_DATOS_CHECK_EN to enable the
// sticky error flag; otherwise error is tied low.
// Revision: 1.0
// ============================================================================
`default_nettype none

module camino_datos_mult
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   multiplicando,
    input  logic [WIDTH-1:0]   multiplicador,
    input  logic               CargaQ,
    input  logic               DesplazaQ,
    input  logic               ResetA,
    input  logic               CargaA,
    input  logic               Fin,
    output logic               q0,
    output logic [2*WIDTH-1:0] producto,
    output logic               producto_valido,
    output logic               ocupado,
    output logic               error
);

    localparam int CNT_W = calc_cnt_w(WIDTH);

    logic [WIDTH-1:0] m_reg;
    logic [WIDTH-1:0] a_reg;
    logic             c_reg;
    logic [WIDTH-1:0] q_reg;
    logic             fin_q;
    logic             fin_edge;
    logic             lleno;
    logic [WIDTH:0]   suma;
    logic [WIDTH:0]   acc_next;

    assign q0       = q_reg[0];
    assign fin_edge = Fin && !fin_q;
    assign suma     = {1'b0, a_reg} + {1'b0, m_reg};

    // {C,A} after ResetA / CargaA, before any shift in the same cycle.
    always_comb begin
        acc_next = {c_reg, a_reg};
        if (ResetA) begin
            acc_next = '0;
        end else if (CargaA) begin
            acc_next = suma;
        end
    end

    contador_desplazamientos #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_contador (
        .clk   (clk),
        .reset (reset),
        .clear (CargaQ),
        .inc   (DesplazaQ && !CargaQ),
        .lleno (lleno)
    );

    // Operand and accumulator registers; CargaQ overrides add and shift.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_reg <= '0;
            a_reg <= '0;
            c_reg <= 1'b0;
            q_reg <= '0;
        end else if (CargaQ) begin
            m_reg <= multiplicando;
            q_reg <= multiplicador;
            if (ResetA) begin
                a_reg <= '0;
                c_reg <= 1'b0;
            end
        end else if (DesplazaQ) begin
            a_reg <= acc_next[WIDTH:1];
            q_reg <= {acc_next[0], q_reg[WIDTH-1:1]};
            c_reg <= 1'b0;
        end else begin
            a_reg <= acc_next[WIDTH-1:0];
            c_reg <= acc_next[WIDTH];
        end
    end

    // Product capture on the rising edge of Fin and the busy flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fin_q           <= 1'b0;
            producto        <= '0;
            producto_valido <= 1'b0;
            ocupado         <= 1'b0;
        end else begin
            fin_q           <= Fin;
            producto_valido <= fin_edge;
            if (fin_edge) begin
                producto <= {a_reg, q_reg};
                ocupado  <= 1'b0;
            end
            // A load in the same cycle starts a new operation, so it stays busy.
            if (CargaQ) begin
                ocupado <= 1'b1;
            end
        end
    end

`ifdef CAMINO_DATOS_CHECK_EN
    logic error_reg;

    assign error = error_reg;

    // Sticky protocol-violation flag, cleared only by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_reg <= 1'b0;
        end else if ((DesplazaQ && lleno) ||
                     ((CargaA || DesplazaQ) && !ocupado) ||
                     (CargaQ && (CargaA || DesplazaQ)) ||
                     (fin_edge && !lleno)) begin
            error_reg <= 1'b1;
        end
    end
`else
    assign error = 1'b0;
`endif

endmodule

`default_nettype wire
